i2cs: RTL and testbench

//  I2C target (slave) byte engine, the bus-side counterpart of the i2cm master. Detects START, repeated START
//  and STOP. Matches a 7-bit address, ACKs written bytes and delivers each one to the user as a 1-cycle pulse.

---
 rtl/i2cs.sv | 274 +++++++++++++++++++++++++++
 tb/tb_i2cs.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cs.sv
`timescale 1ns/1ps
// i2cs - I2C target byte engine.
//   Detects START / repeated START / STOP on glitch-filtered pads, matches a
//   7-bit address, ACKs written bytes and delivers them as rx_valid pulses,
//   serves read bytes through tx_valid/tx_ready while stretching SCL.
//   Pads are open-drain: *_o tied 0, *_oe=1 pulls the line low.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   i2c_scl_i/_o/_oe            SCL pad (oe = stretch)
//   i2c_sda_i/_o/_oe            SDA pad (oe = ACK or data 0)
//   rx_valid, rx_data, rx_first received write byte (first = register index)
//   tx_ready, tx_valid, tx_data read byte handshake
//   evt_start, evt_stop, busy   bus event pulses, address-matched status
//
// state  | meaning
// IDLE   | bus free, waiting for START
// ADDR   | shifting in address + R/W
// AACK   | driving ACK for our address
// WRITE  | shifting in a write byte
// WACK   | driving ACK for a write byte
// LOAD   | SCL stretched, waiting for a read byte
// READ   | shifting out a read byte
// MACK   | sampling the master's ACK/NACK
// IGNORE | not addressed or NACKed, lines released
module i2cs #(
  parameter logic [6:0]  SADDR = 7'h50,
  parameter int unsigned FILT  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i2c_scl_i,
  output logic       i2c_scl_o,
  output logic       i2c_scl_oe,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic       i2c_sda_oe,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_first,
  output logic       tx_ready,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       evt_start,
  output logic       evt_stop,
  output logic       busy
);

  localparam int unsigned   FW    = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [FW-1:0] FLOAD = FW'(FILT - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_AACK, ST_WRITE, ST_WACK,
    ST_LOAD, ST_READ, ST_MACK, ST_IGNORE
  } state_t;

  // index 0 = SCL, 1 = SDA; idle bus level is high so reset there
  logic [1:0]    w_pad;
  logic [1:0]    r_sync1, r_sync2, r_flt, r_flt_d;
  logic [FW-1:0] r_fcnt [2];

  assign w_pad = {i2c_sda_i, i2c_scl_i};

  // A new level is accepted after FILT consecutive samples that differ from
  // the current filtered level; the down-counter reloads on any agreeing sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_flt   <= 2'b11;
      r_flt_d <= 2'b11;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= FLOAD;
    end else begin
      r_sync1 <= w_pad;
      r_sync2 <= r_sync1;
      r_flt_d <= r_flt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_flt[i]) begin
          r_fcnt[i] <= FLOAD;
        end else if (r_fcnt[i] == '0) begin
          r_flt[i]  <= r_sync2[i];
          r_fcnt[i] <= FLOAD;
        end else begin
          r_fcnt[i] <= r_fcnt[i] - 1'b1;
        end
      end
    end
  end

  logic w_sda, w_scl_r, w_scl_f, w_start, w_stop;
  assign w_sda   = r_flt[1];
  assign w_scl_r =  r_flt[0] & ~r_flt_d[0];
  assign w_scl_f = ~r_flt[0] &  r_flt_d[0];
  // SCL must be high on both samples so a simultaneous SCL/SDA move is not a bus condition
  assign w_start =  r_flt_d[1] & ~r_flt[1] & r_flt[0] & r_flt_d[0];
  assign w_stop  = ~r_flt_d[1] &  r_flt[1] & r_flt[0] & r_flt_d[0];

  state_t     r_state, w_state_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic [7:0] r_shift, w_shift_nx, r_rx_data, w_rx_data_nx, w_byte;
  logic       r_sda_oe, w_sda_oe_nx, r_scl_oe, w_scl_oe_nx;
  logic       r_ph, w_ph_nx, r_rw, w_rw_nx, r_first, w_first_nx, r_busy, w_busy_nx;
  logic       r_rx_valid, w_rx_valid_nx, r_rx_first, w_rx_first_nx;
  logic       r_evt_start, w_evt_start_nx, r_evt_stop, w_evt_stop_nx;

  assign w_byte = {r_shift[6:0], w_sda};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd7;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_sda_oe    <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_ph        <= 1'b0;
      r_rw        <= 1'b0;
      r_first     <= 1'b0;
      r_busy      <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_first  <= 1'b0;
      r_evt_start <= 1'b0;
      r_evt_stop  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_shift     <= w_shift_nx;
      r_rx_data   <= w_rx_data_nx;
      r_sda_oe    <= w_sda_oe_nx;
      r_scl_oe    <= w_scl_oe_nx;
      r_ph        <= w_ph_nx;
      r_rw        <= w_rw_nx;
      r_first     <= w_first_nx;
      r_busy      <= w_busy_nx;
      r_rx_valid  <= w_rx_valid_nx;
      r_rx_first  <= w_rx_first_nx;
      r_evt_start <= w_evt_start_nx;
      r_evt_stop  <= w_evt_stop_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_shift_nx     = r_shift;
    w_rx_data_nx   = r_rx_data;
    w_sda_oe_nx    = r_sda_oe;
    w_scl_oe_nx    = r_scl_oe;
    w_ph_nx        = r_ph;
    w_rw_nx        = r_rw;
    w_first_nx     = r_first;
    w_busy_nx      = r_busy;
    w_rx_valid_nx  = 1'b0;
    w_rx_first_nx  = 1'b0;
    w_evt_start_nx = 1'b0;
    w_evt_stop_nx  = 1'b0;
    if (w_start) begin
      w_state_nx     = ST_ADDR;
      w_cnt_nx       = 3'd7;
      w_sda_oe_nx    = 1'b0;
      w_scl_oe_nx    = 1'b0;
      w_ph_nx        = 1'b0;
      w_first_nx     = 1'b1;
      w_busy_nx      = 1'b0;
      w_evt_start_nx = 1'b1;
    end else if (w_stop) begin
      w_state_nx    = ST_IDLE;
      w_sda_oe_nx   = 1'b0;
      w_scl_oe_nx   = 1'b0;
      w_ph_nx       = 1'b0;
      w_busy_nx     = 1'b0;
      w_evt_stop_nx = 1'b1;
    end else begin
      case (r_state)
        ST_ADDR: if (w_scl_r) begin
          w_shift_nx = w_byte;
          if (r_cnt == 3'd0) begin
            w_cnt_nx = 3'd7;
            if (w_byte[7:1] == SADDR) begin
              w_busy_nx  = 1'b1;
              w_rw_nx    = w_byte[0];
              w_ph_nx    = 1'b0;
              w_state_nx = ST_AACK;
            end else begin
              w_state_nx = ST_IGNORE;
            end
          end else begin
            w_cnt_nx = r_cnt - 3'd1;
          end
        end
        // r_ph: 0 = ACK not yet driven, 1 = ACK on the bus until the 9th falling edge
        ST_AACK, ST_WACK: if (w_scl_f) begin
          if (!r_ph) begin
            w_sda_oe_nx = 1'b1;
            w_ph_nx     = 1'b1;
          end else begin
            w_sda_oe_nx = 1'b0;
            w_ph_nx     = 1'b0;
            if (r_state == ST_AACK && r_rw) begin
              w_state_nx  = ST_LOAD;
              w_scl_oe_nx = 1'b1;
            end else begin
              w_state_nx = ST_WRITE;
              w_cnt_nx   = 3'd7;
            end
          end
        end
        ST_WRITE: if (w_scl_r) begin
          w_shift_nx = w_byte;
          if (r_cnt == 3'd0) begin
            w_rx_valid_nx = 1'b1;
            w_rx_data_nx  = w_byte;
            w_rx_first_nx = r_first;
            w_first_nx    = 1'b0;
            w_ph_nx       = 1'b0;
            w_cnt_nx      = 3'd7;
            w_state_nx    = ST_WACK;
          end else begin
            w_cnt_nx = r_cnt - 3'd1;
          end
        end
        // SDA and SCL registers update on the same edge, so SCL is released
        // exactly when bit 7 appears on SDA
        ST_LOAD: begin
          w_scl_oe_nx = 1'b1;
          if (tx_valid) begin
            w_shift_nx  = tx_data;
            w_sda_oe_nx = ~tx_data[7];
            w_scl_oe_nx = 1'b0;
            w_cnt_nx    = 3'd7;
            w_state_nx  = ST_READ;
          end
        end
        ST_READ: if (w_scl_f) begin
          if (r_cnt == 3'd0) begin
            w_sda_oe_nx = 1'b0;
            w_ph_nx     = 1'b0;
            w_state_nx  = ST_MACK;
          end else begin
            w_sda_oe_nx = ~r_shift[6];
            w_shift_nx  = {r_shift[6:0], 1'b0};
            w_cnt_nx    = r_cnt - 3'd1;
          end
        end
        ST_MACK: begin
          if (!r_ph) begin
            if (w_scl_r) begin
              if (w_sda) w_state_nx = ST_IGNORE;
              else       w_ph_nx    = 1'b1;
            end
          end else if (w_scl_f) begin
            w_ph_nx     = 1'b0;
            w_scl_oe_nx = 1'b1;
            w_state_nx  = ST_LOAD;
          end
        end
        ST_IDLE, ST_IGNORE: ;
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  assign i2c_scl_o  = 1'b0;
  assign i2c_sda_o  = 1'b0;
  assign i2c_scl_oe = r_scl_oe;
  assign i2c_sda_oe = r_sda_oe;
  assign rx_valid   = r_rx_valid;
  assign rx_data    = r_rx_data;
  assign rx_first   = r_rx_first;
  assign tx_ready   = (r_state == ST_LOAD);
  assign evt_start  = r_evt_start;
  assign evt_stop   = r_evt_stop;
  assign busy       = r_busy;

endmodule

// File: tb/tb_i2cs.sv
`timescale 1ns/1ps
// Testbench for i2cs: bit-level open-drain master model, user-side tx agent,
// rx and read-data scoreboards, table of write transactions plus hand-written
// read, stretch, repeated-START, glitch and reset sequences.
module tb_i2cs;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic m_scl = 1'b1, m_sda = 1'b1;
  logic scl_o, scl_oe, sda_o, sda_oe, scl_line, sda_line;
  logic rx_valid, rx_first, tx_ready, tx_valid, evt_start, evt_stop, busy;
  logic [7:0] rx_data, tx_data;

  assign scl_line = m_scl & ~scl_oe;
  assign sda_line = m_sda & ~sda_oe;

  i2cs #(.SADDR(7'h50), .FILT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i2c_scl_i(scl_line), .i2c_scl_o(scl_o), .i2c_scl_oe(scl_oe),
    .i2c_sda_i(sda_line), .i2c_sda_o(sda_o), .i2c_sda_oe(sda_oe),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_first(rx_first),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
    .evt_start(evt_start), .evt_stop(evt_stop), .busy(busy)
  );

  int n_chk = 0, n_err = 0;
  int n_start = 0, n_stop = 0, n_rx = 0, n_oe = 0, n_busy = 0;
  int n_rdy_rise = 0, n_stretch = 0, n_stretch_bad = 0, n_hs = 0;
  logic [8:0] rx_exp[$];   // {first, data}
  logic [7:0] rd_exp[$];
  logic [7:0] tx_src[$];
  int  tx_hold = 0;
  bit  tx_burst = 0;

  task automatic summary_and_finish();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: sampled on the falling clock edge
  initial begin
    logic rdy_d;
    logic [8:0] e;
    rdy_d = 1'b0;
    forever begin
      @(negedge clk);
      if (evt_start) n_start++;
      if (evt_stop) n_stop++;
      if (sda_oe || scl_oe) n_oe++;
      if (busy) n_busy++;
      if (tx_ready && !rdy_d) n_rdy_rise++;
      rdy_d = tx_ready;
      if (tx_ready && m_scl) n_stretch++;
      if (tx_ready && scl_line) n_stretch_bad++;
      if (rx_valid) begin
        n_rx++;
        if (rx_exp.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL rx_unexpected: got %0h want none", rx_data);
        end else begin
          e = rx_exp.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
          check("rx_first", {31'd0, rx_first}, {31'd0, e[8]});
        end
      end
    end
  end

  // user-side read agent: offers tx_src bytes after tx_hold ready cycles
  initial begin
    int waited;
    waited = 0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_ready && tx_src.size() > 0 && waited >= tx_hold) begin
        tx_valid = 1'b1;
        tx_data = tx_src.pop_front();
        rd_exp.push_back(tx_data);
        n_hs++;
        waited = 0;
        @(posedge clk); #1;
        tx_valid = tx_burst;
        tx_data = (tx_src.size() > 0) ? tx_src[0] : 8'hEE;
      end else begin
        if (tx_ready && tx_src.size() > 0) waited++;
        if (!tx_burst) tx_valid = 1'b0;
        else if (tx_src.size() > 0) begin
          tx_valid = 1'b1;
          tx_data = tx_src[0];
        end
      end
    end
  end

  initial begin
    #800000;
    n_chk++;
    n_err++;
    $display("FAIL watchdog: got timeout want completion");
    summary_and_finish();
  end

  task automatic qwait();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic scl_high();
    int k;
    k = 0;
    m_scl = 1'b1;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!scl_line && k < 5000);
    if (!scl_line) begin
      n_chk++;
      n_err++;
      $display("FAIL scl_release: got stuck-low want high");
      summary_and_finish();
    end
  endtask

  task automatic m_start();
    m_sda = 1'b1; qwait();
    scl_high(); qwait();
    m_sda = 1'b0; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic m_stop();
    m_sda = 1'b0; qwait();
    scl_high(); qwait();
    m_sda = 1'b1; qwait();
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda = b; qwait();
    scl_high(); qwait();
    r = sda_line; qwait();
    m_scl = 1'b0; qwait();
  endtask

  task automatic m_write(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic m_read(input logic ack, input string name);
    logic r;
    logic [7:0] d;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, r);
      d = {d[6:0], r};
    end
    m_bit(~ack, r);
    if (rd_exp.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got %0h want none", name, d);
    end else begin
      check(name, {24'd0, d}, {24'd0, rd_exp.pop_front()});
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] d0;
    logic [7:0] d1;
    int         nd;
    logic       exp_ack;
  } wvec_t;

  wvec_t vec[6];

  initial begin
    logic ack, r;
    logic [7:0] d;
    int s0, p0, r0, o0, b0, h0, q0, t0, x0;

    vec[0] = '{8'hA0, 8'h12, 8'h34, 2, 1'b1};
    vec[1] = '{8'hA2, 8'h55, 8'h00, 1, 1'b0};
    vec[2] = '{8'hA0, 8'hFF, 8'h00, 2, 1'b1};
    vec[3] = '{8'h20, 8'h5A, 8'h00, 1, 1'b0};
    vec[4] = '{8'hA0, 8'h80, 8'h00, 1, 1'b1};
    vec[5] = '{8'hB0, 8'hC1, 8'h3C, 2, 1'b0};

    repeat (5) @(posedge clk); #1;
    check("reset_outs", {19'd0, scl_o, scl_oe, sda_o, sda_oe, rx_valid, rx_first,
                         tx_ready, evt_start, evt_stop, busy, rx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    check("post_reset_events", n_start + n_stop, 0);

    // table-driven write transactions
    for (int v = 0; v < 6; v++) begin
      s0 = n_start; p0 = n_stop; r0 = n_rx; o0 = n_oe; b0 = n_busy;
      m_start();
      m_write(vec[v].addr, ack);
      check($sformatf("v%0d addr_ack", v), {31'd0, ack}, {31'd0, vec[v].exp_ack});
      check($sformatf("v%0d busy", v), {31'd0, busy}, {31'd0, vec[v].exp_ack});
      for (int j = 0; j < vec[v].nd; j++) begin
        d = (j == 0) ? vec[v].d0 : vec[v].d1;
        if (vec[v].exp_ack) rx_exp.push_back({(j == 0), d});
        m_write(d, ack);
        check($sformatf("v%0d data%0d_ack", v, j), {31'd0, ack}, {31'd0, vec[v].exp_ack});
      end
      m_stop();
      qwait();
      check($sformatf("v%0d starts", v), n_start - s0, 1);
      check($sformatf("v%0d stops", v), n_stop - p0, 1);
      check($sformatf("v%0d rx_count", v), n_rx - r0, vec[v].exp_ack ? vec[v].nd : 0);
      check($sformatf("v%0d busy_end", v), {31'd0, busy}, 0);
      check($sformatf("v%0d oe_activity", v), {31'd0, (n_oe != o0)}, {31'd0, vec[v].exp_ack});
      check($sformatf("v%0d busy_seen", v), {31'd0, (n_busy != b0)}, {31'd0, vec[v].exp_ack});
      check($sformatf("v%0d rx_pending", v), rx_exp.size(), 0);
    end

    // read with a 200-clk stretch, master NACK
    s0 = n_start; p0 = n_stop;
    tx_hold = 200;
    tx_src.push_back(8'hC3);
    m_start();
    m_write(8'hA1, ack);
    check("rd_addr_ack", {31'd0, ack}, 1);
    t0 = n_stretch; x0 = n_stretch_bad;
    m_read(1'b0, "rd_stretch_data");
    check("rd_stretch_long", {31'd0, (n_stretch - t0 >= 150)}, 1);
    check("rd_stretch_scl_low", n_stretch_bad - x0, 0);
    qwait();
    check("rd_nack_busy_held", {31'd0, busy}, 1);
    check("rd_nack_no_ready", {31'd0, tx_ready}, 0);
    m_stop();
    qwait();
    check("rd_busy_end", {31'd0, busy}, 0);
    check("rd_events", (n_start - s0) * 16 + (n_stop - p0), 17);
    tx_hold = 0;

    // burst read, tx_valid always high
    h0 = n_hs; q0 = n_rdy_rise;
    tx_src.push_back(8'h01); tx_src.push_back(8'h02);
    tx_src.push_back(8'h03); tx_src.push_back(8'h04);
    tx_burst = 1'b1;
    m_start();
    m_write(8'hA1, ack);
    check("burst_addr_ack", {31'd0, ack}, 1);
    m_read(1'b1, "burst_b0");
    m_read(1'b1, "burst_b1");
    m_read(1'b0, "burst_b2");
    repeat (3 * Q) @(posedge clk); #1;
    m_stop();
    qwait();
    check("burst_handshakes", n_hs - h0, 3);
    check("burst_ready_rises", n_rdy_rise - q0, 3);
    check("burst_leftover", tx_src.size(), 1);
    tx_burst = 1'b0;
    tx_src.delete();
    qwait();

    // write then repeated START into a read
    s0 = n_start; p0 = n_stop; r0 = n_rx;
    m_start();
    m_write(8'hA0, ack);
    check("sr_waddr_ack", {31'd0, ack}, 1);
    rx_exp.push_back({1'b1, 8'h07});
    m_write(8'h07, ack);
    check("sr_wdata_ack", {31'd0, ack}, 1);
    tx_hold = 3;
    tx_src.push_back(8'h5A);
    m_start();
    m_write(8'hA1, ack);
    check("sr_raddr_ack", {31'd0, ack}, 1);
    m_read(1'b0, "sr_read");
    m_stop();
    qwait();
    check("sr_starts", n_start - s0, 2);
    check("sr_stops", n_stop - p0, 1);
    check("sr_rx_count", n_rx - r0, 1);
    tx_hold = 0;

    // repeated START in the middle of a write byte drops the partial byte
    r0 = n_rx;
    m_start();
    m_write(8'hA0, ack);
    m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r);
    m_start();
    m_write(8'hA0, ack);
    rx_exp.push_back({1'b1, 8'h44});
    m_write(8'h44, ack);
    m_stop();
    qwait();
    check("abort_rx_count", n_rx - r0, 1);
    check("abort_rx_pending", rx_exp.size(), 0);

    // SDA spikes of 1 and 2 clocks on an idle bus
    s0 = n_start; p0 = n_stop;
    for (int w = 1; w <= 2; w++) begin
      @(posedge clk); #1;
      m_sda = 1'b0;
      repeat (w) @(posedge clk);
      #1;
      m_sda = 1'b1;
      repeat (12) @(posedge clk);
    end
    #1;
    check("glitch_no_start", n_start - s0, 0);
    check("glitch_no_stop", n_stop - p0, 0);

    // reset in the middle of a read byte
    tx_src.push_back(8'h00);
    m_start();
    m_write(8'hA1, ack);
    m_bit(1'b1, r); m_bit(1'b1, r); m_bit(1'b1, r);
    check("mid_read_driving", {31'd0, sda_oe}, 1);
    rst_n = 1'b0;
    #1;
    check("reset_release", {30'd0, sda_oe, scl_oe}, 0);
    check("reset_busy_ready", {30'd0, busy, tx_ready}, 0);
    rd_exp.delete();
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    m_stop();
    qwait();
    r0 = n_rx;
    m_start();
    m_write(8'hA0, ack);
    check("after_reset_ack", {31'd0, ack}, 1);
    rx_exp.push_back({1'b1, 8'h9C});
    m_write(8'h9C, ack);
    m_stop();
    qwait();
    check("after_reset_rx", n_rx - r0, 1);
    check("end_rx_pending", rx_exp.size(), 0);
    check("end_rd_pending", rd_exp.size(), 0);

    summary_and_finish();
  end
endmodule
